cpu_control_unit: RTL and testbench

Moore/Mealy control FSM that sequences the accumulator datapath (AR, PC, DR, IR, ACC, ALU) through fetch, decode and execute. It drives every datapath load, increment and bus-enable strobe. It also handles the memory read/write handshake, including wait states. It sits between the instruction memory/bus and the Calculation_and_Register datapath and is the only source of its control strobes.

---
 rtl/cpu_control_unit.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Control FSM for the accumulator datapath (AR, PC, DR, IR, ACC, ALU).
//   It sequences fetch (F1-F3), decode (DEC) and a short execute phase, and
//   it is the only source of the datapath strobes. Memory reads and writes
//   stall in place until mem_ready.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   start            : one-cycle pulse; leaves IDLE/HALTED and starts a fetch
//   instr[OPW]       : opcode from IR[15:12], sampled in DEC
//   acc_zero         : ACC == 0, sampled in DEC for JMPZ/JPNZ
//   mem_ready        : memory finishes the current read/write this cycle
//   arload .. ac_inc : datapath load/increment/bus strobes
//   irbus, acbus     : drive IR[11:0] or ACC onto the bus
//   alusel[ALUW]     : ALU function, used only with ac_load
//   mem_read/write   : memory request, held until mem_ready
//   halted, busy     : status (HALTED / any state except IDLE and HALTED)
module cpu_control_unit #(
   parameter int OPW  = 4,
   parameter int ALUW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [OPW-1:0]  instr,
   input  logic            acc_zero,
   input  logic            mem_ready,
   output logic            arload,
   output logic            pcload,
   output logic            pcinc,
   output logic            pcbus,
   output logic            drload,
   output logic            drbus,
   output logic            membus,
   output logic            irload,
   output logic            ac_load,
   output logic            ac_inc,
   output logic            irbus,
   output logic            acbus,
   output logic [ALUW-1:0] alusel,
   output logic            mem_read,
   output logic            mem_write,
   output logic            halted,
   output logic            busy
);

   localparam logic [OPW-1:0] OP_LDAC = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_STAC = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_AND  = OPW'(4'h5);
   localparam logic [OPW-1:0] OP_OR   = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_XOR  = OPW'(4'h7);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(4'h8);
   localparam logic [OPW-1:0] OP_INAC = OPW'(4'h9);
   localparam logic [OPW-1:0] OP_CLAC = OPW'(4'hA);
   localparam logic [OPW-1:0] OP_JUMP = OPW'(4'hB);
   localparam logic [OPW-1:0] OP_JMPZ = OPW'(4'hC);
   localparam logic [OPW-1:0] OP_JPNZ = OPW'(4'hD);
   localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

   localparam logic [ALUW-1:0] ALU_ADD  = ALUW'(3'b000);
   localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(3'b001);
   localparam logic [ALUW-1:0] ALU_AND  = ALUW'(3'b010);
   localparam logic [ALUW-1:0] ALU_OR   = ALUW'(3'b011);
   localparam logic [ALUW-1:0] ALU_XOR  = ALUW'(3'b100);
   localparam logic [ALUW-1:0] ALU_NOT  = ALUW'(3'b101);
   localparam logic [ALUW-1:0] ALU_PASS = ALUW'(3'b110);
   localparam logic [ALUW-1:0] ALU_CLR  = ALUW'(3'b111);

   typedef enum logic [3:0] {
      S_IDLE, S_HALT, S_F1, S_F2, S_F3, S_DEC,
      S_M1, S_M2, S_M3,          // memory-operand ops (LDAC, ADD..XOR)
      S_S1, S_S2,                // STAC
      S_NOT, S_CLAC, S_INAC,     // single-cycle ACC ops
      S_JMP, S_NOJMP             // jump taken / conditional not taken
   } state_t;

   state_t         state_q, state_d;
   logic [OPW-1:0] op_q;   // opcode captured in DEC, needed again in M3

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DEC) op_q <= instr;
      end
   end

   always_comb begin
      state_d   = state_q;
      arload    = 1'b0;
      pcload    = 1'b0;
      pcinc     = 1'b0;
      pcbus     = 1'b0;
      drload    = 1'b0;
      drbus     = 1'b0;
      membus    = 1'b0;
      irload    = 1'b0;
      ac_load   = 1'b0;
      ac_inc    = 1'b0;
      irbus     = 1'b0;
      acbus     = 1'b0;
      alusel    = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      halted    = (state_q == S_HALT);
      busy      = (state_q != S_IDLE) && (state_q != S_HALT);
      unique case (state_q)
         S_IDLE, S_HALT: if (start) state_d = S_F1;
         S_F1: begin
            pcbus   = 1'b1;
            arload  = 1'b1;
            state_d = S_F2;
         end
         S_F2: begin
            mem_read = 1'b1;
            membus   = 1'b1;
            if (mem_ready) begin
               drload  = 1'b1;
               pcinc   = 1'b1;
               state_d = S_F3;
            end
         end
         S_F3: begin
            drbus   = 1'b1;
            irload  = 1'b1;
            state_d = S_DEC;
         end
         S_DEC: begin
            unique case (instr)
               OP_LDAC, OP_ADD, OP_SUB,
               OP_AND, OP_OR, OP_XOR: state_d = S_M1;
               OP_STAC:               state_d = S_S1;
               OP_NOT:                state_d = S_NOT;
               OP_INAC:               state_d = S_INAC;
               OP_CLAC:               state_d = S_CLAC;
               OP_JUMP:               state_d = S_JMP;
               OP_JMPZ:               state_d = acc_zero ? S_JMP : S_NOJMP;
               OP_JPNZ:               state_d = acc_zero ? S_NOJMP : S_JMP;
               OP_HALT:               state_d = S_HALT;
               default:               state_d = S_F1;   // NOP and reserved
            endcase
         end
         S_M1, S_S1: begin
            irbus   = 1'b1;
            arload  = 1'b1;
            state_d = (state_q == S_M1) ? S_M2 : S_S2;
         end
         S_M2: begin
            mem_read = 1'b1;
            membus   = 1'b1;
            if (mem_ready) begin
               drload  = 1'b1;
               state_d = S_M3;
            end
         end
         S_M3: begin
            ac_load = 1'b1;
            unique case (op_q)
               OP_ADD:  alusel = ALU_ADD;
               OP_SUB:  alusel = ALU_SUB;
               OP_AND:  alusel = ALU_AND;
               OP_OR:   alusel = ALU_OR;
               OP_XOR:  alusel = ALU_XOR;
               default: alusel = ALU_PASS;   // LDAC
            endcase
            state_d = S_F1;
         end
         S_S2: begin
            acbus     = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_d = S_F1;
         end
         S_NOT: begin
            ac_load = 1'b1;
            alusel  = ALU_NOT;
            state_d = S_F1;
         end
         S_CLAC: begin
            ac_load = 1'b1;
            alusel  = ALU_CLR;
            state_d = S_F1;
         end
         S_INAC: begin
            ac_inc  = 1'b1;
            state_d = S_F1;
         end
         S_JMP: begin
            irbus   = 1'b1;
            pcload  = 1'b1;
            state_d = S_F1;
         end
         S_NOJMP: state_d = S_F1;
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

   logic       clk = 1'b0;
   logic       rst_n, start, acc_zero, mem_ready;
   logic [3:0] instr;
   logic       arload, pcload, pcinc, pcbus, drload, drbus, membus, irload;
   logic       ac_load, ac_inc, irbus, acbus, mem_read, mem_write, halted, busy;
   logic [2:0] alusel;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   cpu_control_unit #(.OPW(4), .ALUW(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
      .acc_zero(acc_zero), .mem_ready(mem_ready),
      .arload(arload), .pcload(pcload), .pcinc(pcinc), .pcbus(pcbus),
      .drload(drload), .drbus(drbus), .membus(membus), .irload(irload),
      .ac_load(ac_load), .ac_inc(ac_inc), .irbus(irbus), .acbus(acbus),
      .alusel(alusel), .mem_read(mem_read), .mem_write(mem_write),
      .halted(halted), .busy(busy)
   );

   // Observed output vector, fixed bit order used by the expected masks.
   localparam logic [18:0] V_ARLOAD = 19'b1 << 18;
   localparam logic [18:0] V_PCLOAD = 19'b1 << 17;
   localparam logic [18:0] V_PCINC  = 19'b1 << 16;
   localparam logic [18:0] V_PCBUS  = 19'b1 << 15;
   localparam logic [18:0] V_DRLOAD = 19'b1 << 14;
   localparam logic [18:0] V_DRBUS  = 19'b1 << 13;
   localparam logic [18:0] V_MEMBUS = 19'b1 << 12;
   localparam logic [18:0] V_IRLOAD = 19'b1 << 11;
   localparam logic [18:0] V_ACLOAD = 19'b1 << 10;
   localparam logic [18:0] V_ACINC  = 19'b1 << 9;
   localparam logic [18:0] V_IRBUS  = 19'b1 << 8;
   localparam logic [18:0] V_ACBUS  = 19'b1 << 7;
   localparam logic [18:0] V_MRD    = 19'b1 << 3;
   localparam logic [18:0] V_MWR    = 19'b1 << 2;
   localparam logic [18:0] V_HALTED = 19'b1 << 1;
   localparam logic [18:0] V_BUSY   = 19'b1;

   function automatic logic [18:0] al(input logic [2:0] a);
      return {12'b0, a, 4'b0};
   endfunction

   function automatic logic [18:0] obs();
      return {arload, pcload, pcinc, pcbus, drload, drbus, membus, irload,
              ac_load, ac_inc, irbus, acbus, alusel, mem_read, mem_write,
              halted, busy};
   endfunction

   typedef struct packed {
      logic [18:0] v;
      logic        mem;   // memory handshake cycle: mem_ready driven by rdy
      logic        rdy;
      logic        dec;   // decode cycle: instr/acc_zero must be valid
   } exp_t;

   function automatic exp_t mk(input logic [18:0] v, input logic mem,
                               input logic rdy, input logic dec);
      exp_t e;
      e.v = v; e.mem = mem; e.rdy = rdy; e.dec = dec;
      return e;
   endfunction

   // Reference: the cycle-by-cycle strobe list for one whole instruction,
   // starting at the fetch, given the opcode, the acc_zero flag and the
   // number of wait cycles in the fetch read and in the operand access.
   task automatic run_instr(input string name, input logic [3:0] op,
                            input logic az, input int wf, input int wm);
      exp_t q[$];
      logic [18:0] got;
      q.push_back(mk(V_ARLOAD | V_PCBUS | V_BUSY, 0, 0, 0));
      for (int i = 0; i < wf; i++) q.push_back(mk(V_MRD | V_MEMBUS | V_BUSY, 1, 0, 0));
      q.push_back(mk(V_MRD | V_MEMBUS | V_DRLOAD | V_PCINC | V_BUSY, 1, 1, 0));
      q.push_back(mk(V_DRBUS | V_IRLOAD | V_BUSY, 0, 0, 0));
      q.push_back(mk(V_BUSY, 0, 0, 1));
      if (op == 4'h1 || (op >= 4'h3 && op <= 4'h7)) begin
         q.push_back(mk(V_IRBUS | V_ARLOAD | V_BUSY, 0, 0, 0));
         for (int i = 0; i < wm; i++) q.push_back(mk(V_MRD | V_MEMBUS | V_BUSY, 1, 0, 0));
         q.push_back(mk(V_MRD | V_MEMBUS | V_DRLOAD | V_BUSY, 1, 1, 0));
         q.push_back(mk(V_ACLOAD | V_BUSY | al(op == 4'h1 ? 3'd6 : 3'(op - 4'd3)), 0, 0, 0));
      end else if (op == 4'h2) begin
         q.push_back(mk(V_IRBUS | V_ARLOAD | V_BUSY, 0, 0, 0));
         for (int i = 0; i < wm; i++) q.push_back(mk(V_ACBUS | V_MWR | V_BUSY, 1, 0, 0));
         q.push_back(mk(V_ACBUS | V_MWR | V_BUSY, 1, 1, 0));
      end else if (op == 4'h8) q.push_back(mk(V_ACLOAD | V_BUSY | al(3'd5), 0, 0, 0));
      else if (op == 4'hA)     q.push_back(mk(V_ACLOAD | V_BUSY | al(3'd7), 0, 0, 0));
      else if (op == 4'h9)     q.push_back(mk(V_ACINC | V_BUSY, 0, 0, 0));
      else if (op == 4'hB || (op == 4'hC && az) || (op == 4'hD && !az))
         q.push_back(mk(V_IRBUS | V_PCLOAD | V_BUSY, 0, 0, 0));
      else if (op == 4'hC || op == 4'hD)
         q.push_back(mk(V_BUSY, 0, 0, 0));

      foreach (q[k]) begin
         @(negedge clk);
         cyc++;
         start     = 1'($urandom);   // must be ignored while busy
         instr     = q[k].dec ? op : 4'($urandom);
         acc_zero  = q[k].dec ? az : 1'($urandom);
         mem_ready = q[k].mem ? q[k].rdy : 1'($urandom);
         #1;
         got = obs();
         n_tests++;
         if (got !== q[k].v) begin
            n_fail++;
            $display("FAIL %s op=%h step=%0d got=%b exp=%b", name, op, k, got, q[k].v);
         end
         n_tests++;
         if ($countones({pcbus, drbus, membus, irbus, acbus}) > 1) begin
            n_fail++;
            $display("FAIL %s bus_onehot step=%0d got=%b exp=at most one", name, k,
                     {pcbus, drbus, membus, irbus, acbus});
         end
         n_tests++;
         if (mem_read && mem_write) begin
            n_fail++;
            $display("FAIL %s rw_excl step=%0d got=11 exp=not both", name, k);
         end
         n_tests++;
         if (!ac_load && alusel !== 3'b000) begin
            n_fail++;
            $display("FAIL %s alusel_idle step=%0d got=%b exp=000", name, k, alusel);
         end
      end
   endtask

   // One start pulse from IDLE or HALTED; outputs keep the resting state.
   task automatic do_start(input logic from_halt);
      logic [18:0] exp_v;
      exp_v = from_halt ? V_HALTED : 19'b0;
      @(negedge clk);
      start = 1'b1; instr = 4'($urandom); acc_zero = 1'($urandom);
      mem_ready = 1'($urandom);
      #1;
      n_tests++;
      if (obs() !== exp_v) begin
         n_fail++;
         $display("FAIL start_pulse got=%b exp=%b", obs(), exp_v);
      end
   endtask

   task automatic halted_cycles(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0; instr = 4'($urandom); acc_zero = 1'($urandom);
         mem_ready = 1'($urandom);
         #1;
         n_tests++;
         if (obs() !== V_HALTED) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, i, obs(), V_HALTED);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (obs() !== 19'b0) begin
         n_fail++; $display("FAIL reset_low got=%b exp=0", obs());
      end
      @(negedge clk); rst_n = 1'b1; #1;
      n_tests++;
      if (obs() !== 19'b0) begin
         n_fail++; $display("FAIL reset_idle got=%b exp=0", obs());
      end
      do_start(1'b0);
      @(negedge clk); start = 1'b0; #1;
      n_tests++;
      if (obs() !== (V_ARLOAD | V_PCBUS | V_BUSY)) begin
         n_fail++; $display("FAIL reset_f1 got=%b exp=%b", obs(), V_ARLOAD | V_PCBUS | V_BUSY);
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      n_tests++;
      if (obs() !== (V_MRD | V_MEMBUS | V_BUSY)) begin
         n_fail++; $display("FAIL reset_f2 got=%b exp=%b", obs(), V_MRD | V_MEMBUS | V_BUSY);
      end
      #2 rst_n = 1'b0; #1;
      n_tests++;
      if (obs() !== 19'b0) begin
         n_fail++; $display("FAIL reset_async got=%b exp=0", obs());
      end
      @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
      n_tests++;
      if (obs() !== 19'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release got=%b exp=0", obs());
      end
   endtask

   task automatic test_add();
      do_start(1'b0);
      run_instr("add", 4'h3, 1'($urandom), 0, 0);
   endtask

   task automatic test_fetch_wait();
      run_instr("fetch_wait", 4'h0, 1'($urandom), 3, 0);
      run_instr("ldac_wait", 4'h1, 1'($urandom), 1, 2);
   endtask

   task automatic test_branch();
      run_instr("jmpz_taken", 4'hC, 1'b1, 0, 0);
      run_instr("jmpz_not",   4'hC, 1'b0, 0, 0);
      run_instr("jpnz_taken", 4'hD, 1'b0, 0, 0);
      run_instr("jpnz_not",   4'hD, 1'b1, 0, 0);
      run_instr("jump",       4'hB, 1'($urandom), 0, 0);
   endtask

   task automatic test_stac();
      run_instr("stac_wait", 4'h2, 1'($urandom), 0, 2);
   endtask

   task automatic test_halt();
      run_instr("halt", 4'hF, 1'($urandom), 0, 0);
      halted_cycles("halt_hold", 20);
      do_start(1'b1);
      run_instr("after_halt", 4'h0, 1'($urandom), 0, 0);
   endtask

   task automatic test_random();
      logic [3:0] op;
      while (cyc < 10000) begin
         op = 4'($urandom);
         run_instr("random", op, 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         if (op == 4'hF) begin
            halted_cycles("random_halt", 2);
            do_start(1'b1);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; instr = 4'h0; acc_zero = 1'b0; mem_ready = 1'b1;
      test_reset();
      test_add();
      test_fetch_wait();
      test_branch();
      test_stac();
      test_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
